// File: rtl/decomp_pkg.sv
// ----------------------------------------------------------------------------
// decomp_pkg
// Shared definitions for the decompression front end: framer FSM state
// encoding, datapath width, compressed-mode field values carried in bits
// [63:62] of the first beat of every packet, and the skid buffer entry layout.
// No ports (package).
// ----------------------------------------------------------------------------
package decomp_pkg;

    localparam int DATA_W = 64;

    // Mode field values found in beat[63:62] of a packet's first beat.
    // SR is any value with the upper bit set (2'b1x).
    localparam logic [1:0] MODE_BPC = 2'b00;
    localparam logic [1:0] MODE_ZRL = 2'b01;
    localparam logic [1:0] MODE_SR  = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } framer_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } skid_entry_t;

endpackage

// File: rtl/decomp_skid_buf.sv
// ----------------------------------------------------------------------------
// decomp_skid_buf
// Two-entry registered valid/ready buffer. The head entry drives the pop side
// straight from registers, so the consumer sees no combinational path from
// the producer's data. Push is accepted while an entry is free, or while full
// if the head is popped in the same cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push_data_i [W-1:0]      payload in
//   push_valid_i             payload valid
//   push_ready_o             buffer can take the payload this cycle
//   pop_data_o  [W-1:0]      head payload
//   pop_valid_o              head entry is occupied
//   pop_ready_i              consumer takes the head this cycle
// ----------------------------------------------------------------------------
module decomp_skid_buf #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] push_data_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    output logic [W-1:0] pop_data_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign pop_valid_o  = (r_count != 2'd0);
    assign pop_data_o   = r_head;
    assign w_pop        = pop_valid_o && pop_ready_i;
    assign push_ready_o = (r_count != 2'd2) || w_pop;
    assign w_push       = push_valid_i && push_ready_o;

    // Storage update. A new entry lands in the head when the buffer is empty
    // (or drains to empty in the same cycle), otherwise behind the head. When
    // full with a simultaneous push and pop, the tail moves up and the new
    // entry takes its place, so the count stays at two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= push_data_i;
                    end else begin
                        r_tail <= push_data_i;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= push_data_i;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/decomp_pkt_framer.sv
// ----------------------------------------------------------------------------
// decomp_pkt_framer
// Turns an unframed 64-bit compressed beat stream plus a per-packet length
// descriptor into the framed stream (data/valid/ready/sop/eop) consumed by the
// decompressor. Beats pass through unmodified, so the mode bits [63:62] of
// the first beat reach the decompressor intact. A 2-entry registered skid
// buffer isolates source timing from decompressor backpressure.
// Optional build macro: DECOMP_FRAMER_STATS_EN adds packet/beat counters.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   desc_len_i          packet length in beats (0 is dropped with len_err_o)
//   desc_valid_i/o_rdy  descriptor handshake (desc_ready_o)
//   data_i/valid_i      source beat, accepted with ready_o
//   data_o/valid_o      framed beat to decompressor, taken with ready_i
//   sop_o/eop_o         first/last beat markers of the packet
//   len_err_o           one-cycle pulse after a zero-length descriptor
//   pkt_cnt_o           (stats build) packets delivered, wraps mod 2^32
//   beat_cnt_o          (stats build) beats delivered, wraps mod 2^32
// ----------------------------------------------------------------------------
module decomp_pkt_framer
    import decomp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  desc_len_i,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              len_err_o
`ifdef DECOMP_FRAMER_STATS_EN
    ,
    output logic [31:0]       pkt_cnt_o,
    output logic [31:0]       beat_cnt_o
`endif
);

    framer_state_t    r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_first;
    logic             r_len_err;

    skid_entry_t      w_push_entry;
    skid_entry_t      w_head_entry;
    logic             w_skid_ready;
    logic             w_skid_valid;
    logic             w_beat_acc;
    logic             w_last_beat;
    logic             w_desc_chain;

    assign w_last_beat  = (r_remaining == LEN_W'(1));
    assign ready_o      = (r_state == ST_STREAM) && w_skid_ready;
    assign w_beat_acc   = valid_i && ready_o;

    // A descriptor arriving together with the last beat of the current packet
    // is taken immediately so back-to-back packets stream without a bubble.
    assign w_desc_chain = w_beat_acc && w_last_beat && desc_valid_i
                          && (desc_len_i != '0);
    assign desc_ready_o = !rst && ((r_state == ST_IDLE) || w_desc_chain);
    assign len_err_o    = r_len_err;

    assign w_push_entry.data = data_i;
    assign w_push_entry.sop  = r_first;
    assign w_push_entry.eop  = w_last_beat;

    decomp_skid_buf #(
        .W ($bits(skid_entry_t))
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .push_data_i  (w_push_entry),
        .push_valid_i (valid_i && (r_state == ST_STREAM)),
        .push_ready_o (w_skid_ready),
        .pop_data_o   (w_head_entry),
        .pop_valid_o  (w_skid_valid),
        .pop_ready_i  (ready_i)
    );

    // Markers are qualified by valid so a drained buffer never shows a stale
    // sop/eop from the entry that just left.
    assign data_o  = w_head_entry.data;
    assign valid_o = w_skid_valid;
    assign sop_o   = w_skid_valid && w_head_entry.sop;
    assign eop_o   = w_skid_valid && w_head_entry.eop;

    // Framer FSM. IDLE waits for a descriptor; a zero length is consumed and
    // flagged. STREAM counts beats down from the loaded length, marking the
    // first and last ones, then either chains straight into the next packet
    // or returns to IDLE. The counter never wraps: it leaves STREAM at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (desc_valid_i) begin
                        if (desc_len_i != '0) begin
                            r_remaining <= desc_len_i;
                            r_first     <= 1'b1;
                            r_state     <= ST_STREAM;
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_beat_acc) begin
                        if (w_last_beat) begin
                            if (w_desc_chain) begin
                                r_remaining <= desc_len_i;
                                r_first     <= 1'b1;
                            end else begin
                                r_remaining <= '0;
                                r_first     <= 1'b0;
                                r_state     <= ST_IDLE;
                            end
                        end else begin
                            r_remaining <= r_remaining - LEN_W'(1);
                            r_first     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DECOMP_FRAMER_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_beat_cnt;

    assign pkt_cnt_o  = r_pkt_cnt;
    assign beat_cnt_o = r_beat_cnt;

    // Delivery statistics, counted on the output handshake only so stalled
    // beats are not counted twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (valid_o && ready_i) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (eop_o) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decomp_pkt_framer.sv
// ----------------------------------------------------------------------------
// tb_decomp_pkt_framer
// Drives descriptors and beats from queues, and compares the DUT every cycle
// against a queue-level model of the framed stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decomp_pkt_framer;

    localparam int LEN_W = 8;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        e;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] desc_len_i;
    logic             desc_valid_i;
    logic             desc_ready_o;
    logic [63:0]      data_i;
    logic             valid_i;
    logic             ready_o;
    logic [63:0]      data_o;
    logic             valid_o;
    logic             ready_i;
    logic             sop_o;
    logic             eop_o;
    logic             len_err_o;

    int nVectors = 0;
    int nMiscompares = 0;

    // Stimulus sources
    logic [63:0]      beatQ[$];
    logic [LEN_W-1:0] descQ[$];
    int validPct = 100;
    int readyPct = 100;
    int descPct  = 100;
    bit beatTaken = 1'b0;
    bit descTaken = 1'b0;

    // Model state: mq holds the beats that must currently sit in the buffer
    beat_t mq[$];
    beat_t outLog[$];
    int    acceptCycles[$];
    int    mRem = 0;
    bit    mFirst = 1'b0;
    bit    mLenErr = 1'b0;
    int    acceptCount = 0;
    int    lenErrCount = 0;
    int    cycle = 0;
    bit    expValid, expPop, expReady, expAccept, expDescReady;
    beat_t nb;

    always #5 clk = ~clk;

    decomp_pkt_framer #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .desc_len_i   (desc_len_i),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sop_o        (sop_o),
        .eop_o        (eop_o),
        .len_err_o    (len_err_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: retire what the last cycle consumed, then drive fresh inputs
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (beatTaken) void'(beatQ.pop_front());
        if (descTaken) void'(descQ.pop_front());
        valid_i      = (beatQ.size() != 0) && ($urandom_range(0, 99) < validPct);
        data_i       = (beatQ.size() != 0) ? beatQ[0] : 64'd0;
        desc_valid_i = (descQ.size() != 0) && ($urandom_range(0, 99) < descPct);
        desc_len_i   = (descQ.size() != 0) ? descQ[0] : '0;
        ready_i      = ($urandom_range(0, 99) < readyPct);
    endtask

    task automatic waitIdle(input int budget);
        int  k = 0;
        bit  idle = 1'b0;
        while (!idle && k < budget) begin
            idle = (beatQ.size() == 0) && (descQ.size() == 0) && (mq.size() == 0)
                   && (mRem == 0) && !mLenErr;
            if (!idle) begin
                applyStimulus();
                k++;
            end
        end
        if (!idle) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL waitIdle: still busy after %0d cycles, want idle", budget);
            beatQ.delete();
            descQ.delete();
        end
        applyStimulus();
    endtask

    // Per-cycle compare at mid-cycle, when inputs and combinational outputs
    // are settled; then advance the model by the handshakes at the next edge.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            checkOutput("rst_valid_o", 64'(valid_o), 64'd0);
            checkOutput("rst_sop_o", 64'(sop_o), 64'd0);
            checkOutput("rst_eop_o", 64'(eop_o), 64'd0);
            checkOutput("rst_len_err_o", 64'(len_err_o), 64'd0);
            checkOutput("rst_desc_ready_o", 64'(desc_ready_o), 64'd0);
            checkOutput("rst_ready_o", 64'(ready_o), 64'd0);
            checkOutput("rst_data_o", data_o, 64'd0);
            mq.delete();
            mRem = 0;
            mFirst = 1'b0;
            mLenErr = 1'b0;
            beatTaken = 1'b0;
            descTaken = 1'b0;
        end else begin
            expValid     = (mq.size() != 0);
            expPop       = expValid && ready_i;
            expReady     = (mRem != 0) && ((mq.size() < 2) || expPop);
            expAccept    = valid_i && expReady;
            expDescReady = (mRem == 0) ||
                           (expAccept && mRem == 1 && desc_valid_i && desc_len_i != 0);
            checkOutput("valid_o", 64'(valid_o), 64'(expValid));
            if (expValid) begin
                checkOutput("data_o", data_o, mq[0].d);
                checkOutput("sop_o", 64'(sop_o), 64'(mq[0].s));
                checkOutput("eop_o", 64'(eop_o), 64'(mq[0].e));
            end
            checkOutput("ready_o", 64'(ready_o), 64'(expReady));
            checkOutput("desc_ready_o", 64'(desc_ready_o), 64'(expDescReady));
            checkOutput("len_err_o", 64'(len_err_o), 64'(mLenErr));
            if (mLenErr) lenErrCount++;
            if (expPop) begin
                outLog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            mLenErr = 1'b0;
            if (expAccept) begin
                nb.d = data_i;
                nb.s = mFirst;
                nb.e = (mRem == 1);
                mq.push_back(nb);
                mFirst = 1'b0;
                mRem--;
                acceptCount++;
                acceptCycles.push_back(cycle);
            end
            if (expDescReady && desc_valid_i) begin
                if (desc_len_i == 0) begin
                    mLenErr = 1'b1;
                end else begin
                    mRem = int'(desc_len_i);
                    mFirst = 1'b1;
                end
            end
            beatTaken = expAccept;
            descTaken = expDescReady && desc_valid_i;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete, want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, a0, c0, e0, eops;
        logic [63:0] t4[4];

        rst = 1'b1;
        desc_len_i = '0;
        desc_valid_i = 1'b0;
        data_i = 64'd0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (3) applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // len=3, three beats, sink always ready
        $display("[TB] test: three-beat packet");
        base = outLog.size();
        descQ.push_back(8'd3);
        beatQ.push_back(64'h0123_4567_89AB_CDEF);
        beatQ.push_back(64'h1111_2222_3333_4444);
        beatQ.push_back(64'hC0DE_0000_0000_00CC);
        waitIdle(100);
        checkOutput("t1_beat0", {outLog[base].d, outLog[base].s, outLog[base].e}, {64'h0123_4567_89AB_CDEF, 2'b10});
        checkOutput("t1_beat1", {outLog[base+1].d, outLog[base+1].s, outLog[base+1].e}, {64'h1111_2222_3333_4444, 2'b00});
        checkOutput("t1_beat2", {outLog[base+2].d, outLog[base+2].s, outLog[base+2].e}, {64'hC0DE_0000_0000_00CC, 2'b01});
        checkOutput("t1_idle_desc_ready", 64'(desc_ready_o), 64'd1);

        // single-beat ZRL packet
        $display("[TB] test: single-beat packet");
        base = outLog.size();
        descQ.push_back(8'd1);
        beatQ.push_back(64'h4000_0000_0000_0001);
        waitIdle(100);
        checkOutput("t2_beat", {outLog[base].d, outLog[base].s, outLog[base].e}, {64'h4000_0000_0000_0001, 2'b11});

        // back-to-back len=2, len=2 without bubble
        $display("[TB] test: back-to-back packets");
        base = outLog.size();
        c0 = acceptCycles.size();
        descQ.push_back(8'd2);
        descQ.push_back(8'd2);
        for (int i = 0; i < 4; i++) beatQ.push_back(64'hB2B0_0000_0000_0000 + 64'(i));
        waitIdle(100);
        for (int i = 0; i < 3; i++)
            checkOutput("t3_accept_gap", 64'(acceptCycles[c0+i+1] - acceptCycles[c0+i]), 64'd1);
        checkOutput("t3_markers", {outLog[base].s, outLog[base].e, outLog[base+1].s, outLog[base+1].e,
                                   outLog[base+2].s, outLog[base+2].e, outLog[base+3].s, outLog[base+3].e},
                    64'b10_01_10_01);

        // stall: sink not ready while a len=4 packet arrives
        $display("[TB] test: backpressure");
        base = outLog.size();
        a0 = acceptCount;
        t4[0] = 64'hD4D4_0000_0000_0001;
        t4[1] = 64'hD4D4_0000_0000_0002;
        t4[2] = 64'hD4D4_0000_0000_0003;
        t4[3] = 64'hD4D4_0000_0000_0004;
        readyPct = 0;
        descQ.push_back(8'd4);
        for (int i = 0; i < 4; i++) beatQ.push_back(t4[i]);
        repeat (7) applyStimulus();
        checkOutput("t4_accepted_while_stalled", 64'(acceptCount - a0), 64'd2);
        checkOutput("t4_hold_valid", 64'(valid_o), 64'd1);
        checkOutput("t4_hold_data", data_o, 64'hD4D4_0000_0000_0001);
        checkOutput("t4_ready_o_full", 64'(ready_o), 64'd0);
        readyPct = 100;
        waitIdle(100);
        for (int i = 0; i < 4; i++) checkOutput("t4_order", outLog[base+i].d, t4[i]);

        // zero-length descriptor then len=2
        $display("[TB] test: zero-length descriptor");
        base = outLog.size();
        e0 = lenErrCount;
        descQ.push_back(8'd0);
        descQ.push_back(8'd2);
        beatQ.push_back(64'h8000_0000_0000_0E01);
        beatQ.push_back(64'h8000_0000_0000_0E02);
        waitIdle(100);
        checkOutput("t5_len_err_pulses", 64'(lenErrCount - e0), 64'd1);
        checkOutput("t5_beats", 64'(outLog.size() - base), 64'd2);
        checkOutput("t5_markers", {outLog[base].s, outLog[base].e, outLog[base+1].s, outLog[base+1].e}, 64'b1001);

        // reset after two of five beats
        $display("[TB] test: reset mid-packet");
        base = outLog.size();
        a0 = acceptCount;
        descQ.push_back(8'd5);
        for (int i = 0; i < 5; i++) beatQ.push_back(64'h5555_0000_0000_0000 + 64'(i));
        for (int k = 0; k < 50 && (acceptCount - a0) < 2; k++) applyStimulus();
        rst = 1'b1;
        beatQ.delete();
        descQ.delete();
        valid_i = 1'b0;
        desc_valid_i = 1'b0;
        #1;
        checkOutput("t6_rst_imm_valid_o", 64'(valid_o), 64'd0);
        checkOutput("t6_rst_imm_sop_o", 64'(sop_o), 64'd0);
        checkOutput("t6_rst_imm_eop_o", 64'(eop_o), 64'd0);
        repeat (2) applyStimulus();
        rst = 1'b0;
        eops = 0;
        for (int i = base; i < outLog.size(); i++) if (outLog[i].e) eops++;
        checkOutput("t6_no_partial_eop", 64'(eops), 64'd0);
        base = outLog.size();
        descQ.push_back(8'd1);
        beatQ.push_back(64'h8000_0000_0000_00AA);
        waitIdle(100);
        checkOutput("t6_after_reset", {outLog[base].d, outLog[base].s, outLog[base].e}, {64'h8000_0000_0000_00AA, 2'b11});

        // maximum length with random stalls
        $display("[TB] test: maximum-length packet");
        base = outLog.size();
        validPct = 80;
        readyPct = 70;
        descQ.push_back(8'd255);
        for (int i = 0; i < 255; i++) beatQ.push_back({$urandom, $urandom});
        waitIdle(3000);
        eops = 0;
        for (int i = base; i < outLog.size(); i++) if (outLog[i].e) eops++;
        checkOutput("t7_beats", 64'(outLog.size() - base), 64'd255);
        checkOutput("t7_first_sop", 64'(outLog[base].s), 64'd1);
        checkOutput("t7_last_eop", 64'(outLog[base+254].e), 64'd1);
        checkOutput("t7_eop_count", 64'(eops), 64'd1);

        // randomized traffic
        $display("[TB] test: random traffic");
        validPct = 75;
        readyPct = 60;
        descPct = 70;
        for (int p = 0; p < 60; p++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            descQ.push_back(LEN_W'(len));
            for (int i = 0; i < len; i++) beatQ.push_back({$urandom, $urandom});
        end
        waitIdle(5000);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
